// File: rtl/modular_exp_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : modular_exp_engine                                         |
// | Description : M^D mod N engine with start/busy/done handshake. Mode 0 is  |
// |               left-to-right square-and-multiply, mode 1 is a Montgomery  |
// |               ladder. One shared bit-serial modular multiplier does all  |
// |               products, WIDTH cycles each. trig marks each exponent bit. |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module modular_exp_engine #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     M,
  input  logic [EXP_WIDTH-1:0] D,
  input  logic [WIDTH-1:0]     N,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 trig,
  output logic [WIDTH-1:0]     result
);

  localparam int c_CW = $clog2(WIDTH + 1);
  localparam int c_BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam int c_AW = WIDTH + 2;

  localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

  localparam logic [2:0] c_IDLE   = 3'd0;
  localparam logic [2:0] c_REDUCE = 3'd1;
  localparam logic [2:0] c_ITER   = 3'd2;
  localparam logic [2:0] c_FIN    = 3'd3;
  localparam logic [2:0] c_ERR    = 3'd4;

  logic [2:0]           r_state;
  logic [2:0]           w_next;

  logic                 r_mode;
  logic [WIDTH-1:0]     r_m;
  logic [EXP_WIDTH-1:0] r_d;      // exponent, current bit kept at the MSB
  logic [WIDTH-1:0]     r_n;
  logic [WIDTH-1:0]     r_a;      // multiplier operand, consumed MSB first
  logic [WIDTH-1:0]     r_b;      // multiplicand operand, always < N
  logic [c_AW-1:0]      r_acc;    // running partial product
  logic [WIDTH-1:0]     r_mp;     // M reduced mod N
  logic [WIDTH-1:0]     r_r0;
  logic [WIDTH-1:0]     r_r1;
  logic [c_CW-1:0]      r_cnt;    // 0 = operand setup, 1..WIDTH = product step
  logic [c_BW-1:0]      r_bit;    // exponent bits still to go after this one
  logic                 r_sub;    // second product of the current bit
  logic                 r_err;
  logic [WIDTH-1:0]     r_result;

  logic [c_AW-1:0]      w_nx;
  logic [c_AW-1:0]      w_dbl;
  logic [c_AW-1:0]      w_s1;
  logic [c_AW-1:0]      w_s2;
  logic [c_AW-1:0]      w_s3;
  logic [WIDTH-1:0]     w_p;
  logic                 w_prod_end;
  logic                 w_first_step;
  logic                 w_setup;
  logic                 w_dbit;
  logic                 w_bit_end;
  logic                 w_last_bit;
  logic                 w_n_small;
  logic [WIDTH-1:0]     w_r0_new;
  logic [WIDTH-1:0]     w_r1_new;

  // One interleaved shift-add step: r = 2r mod N, then r = (r + a_i*b) mod N.
  // Both intermediates stay below 2N, so WIDTH+2 bits never overflow.
  assign w_nx  = {2'b00, r_n};
  assign w_dbl = r_acc << 1;
  assign w_s1  = (w_dbl >= w_nx) ? (w_dbl - w_nx) : w_dbl;
  assign w_s2  = w_s1 + (r_a[WIDTH-1] ? {2'b00, r_b} : '0);
  assign w_s3  = (w_s2 >= w_nx) ? (w_s2 - w_nx) : w_s2;
  assign w_p   = w_s3[WIDTH-1:0];

  assign w_setup      = (r_cnt == '0);
  assign w_first_step = (r_cnt == c_CW'(1));
  assign w_prod_end   = (r_cnt == c_CW'(WIDTH));
  assign w_dbit       = r_d[EXP_WIDTH-1];
  assign w_last_bit   = (r_bit == '0);
  assign w_n_small    = ((r_n >> 1) == '0);

  // Mode 0 ends a bit after the square (bit clear) or the multiply; the
  // ladder always ends a bit after its second product.
  assign w_bit_end = r_mode ? r_sub : (r_sub | ~w_dbit);

  // Register values as they stand once the current bit is complete.
  assign w_r0_new = (r_mode && w_dbit) ? r_r0 : w_p;
  assign w_r1_new = (r_mode && w_dbit) ? w_p  : r_r1;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode; a too-small modulus is flagged after the first reduce step
  // so that done for the error case lands two cycles after the start edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:   if (start) w_next = c_REDUCE;
      c_REDUCE: begin
        if (w_first_step && w_n_small) w_next = c_ERR;
        else if (w_prod_end)           w_next = c_ITER;
      end
      c_ITER:   if (w_prod_end && w_bit_end && w_last_bit) w_next = c_FIN;
      c_FIN:    w_next = c_IDLE;
      c_ERR:    w_next = c_IDLE;
      default:  w_next = c_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    busy   = (r_state == c_REDUCE) || (r_state == c_ITER);
    done   = (r_state == c_FIN) || (r_state == c_ERR);
    trig   = (r_state == c_ITER) && w_first_step && !r_sub;
    err    = r_err;
    result = r_result;
  end

  // Operand latching, multiplier stepping and exponent sequencing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode   <= 1'b0;
      r_m      <= '0;
      r_d      <= '0;
      r_n      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mp     <= '0;
      r_r0     <= '0;
      r_r1     <= '0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_sub    <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_mode <= mode;
            r_m    <= M;
            r_d    <= D;
            r_n    <= N;
            r_cnt  <= '0;
            r_err  <= 1'b0;
          end
        end
        c_REDUCE: begin
          if (w_setup) begin
            // M mod N computed as M * 1
            r_a   <= r_m;
            r_b   <= c_ONE;
            r_acc <= '0;
            r_cnt <= c_CW'(1);
          end else if (w_first_step && w_n_small) begin
            r_err    <= 1'b1;
            r_result <= '0;
          end else if (w_prod_end) begin
            r_mp  <= w_p;
            r_r0  <= c_ONE;
            r_r1  <= w_p;
            r_a   <= c_ONE;
            r_b   <= r_mode ? w_p : c_ONE;
            r_acc <= '0;
            r_cnt <= c_CW'(1);
            r_sub <= 1'b0;
            r_bit <= c_BW'(EXP_WIDTH - 1);
          end else begin
            r_acc <= w_s3;
            r_a   <= r_a << 1;
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        c_ITER: begin
          if (!w_prod_end) begin
            r_acc <= w_s3;
            r_a   <= r_a << 1;
            r_cnt <= r_cnt + c_CW'(1);
          end else if (w_bit_end) begin
            r_r0 <= w_r0_new;
            r_r1 <= w_r1_new;
            if (w_last_bit) begin
              r_result <= w_r0_new;
            end else begin
              r_bit <= r_bit - c_BW'(1);
              r_d   <= r_d << 1;
              r_sub <= 1'b0;
              r_a   <= w_r0_new;
              r_b   <= r_mode ? w_r1_new : w_r0_new;
              r_acc <= '0;
              r_cnt <= c_CW'(1);
            end
          end else begin
            // Second product of this bit; operands are pre-iteration values.
            r_sub <= 1'b1;
            r_acc <= '0;
            r_cnt <= c_CW'(1);
            if (!r_mode) begin
              r_r0 <= w_p;
              r_a  <= w_p;
              r_b  <= r_mp;
            end else if (w_dbit) begin
              r_r0 <= w_p;
              r_a  <= r_r1;
              r_b  <= r_r1;
            end else begin
              r_r1 <= w_p;
              r_a  <= r_r0;
              r_b  <= r_r0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_modular_exp_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_modular_exp_engine                                      |
// | Description : Scoreboard bench for modular_exp_engine (WIDTH=32).        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_modular_exp_engine;

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          trigs;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mode;
  logic [31:0] m_in;
  logic [31:0] d_in;
  logic [31:0] n_in;
  logic        busy;
  logic        done;
  logic        err;
  logic        trig;
  logic [31:0] result;

  int   n_total;
  int   n_bad;
  exp_t sb[$];

  modular_exp_engine #(.WIDTH(32), .EXP_WIDTH(32)) u_dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .M      (m_in),
    .D      (d_in),
    .N      (n_in),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .trig   (trig),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Right-to-left binary exponentiation on 64-bit integers.
  function automatic logic [31:0] ref_modexp(input logic [31:0] m, input logic [31:0] d,
                                             input logic [31:0] n);
    longint unsigned r, b, nn;
    nn = 64'(n);
    r  = 64'd1 % nn;
    b  = 64'(m) % nn;
    for (int i = 0; i < 32; i++) begin
      if (d[i]) r = (r * b) % nn;
      b = (b * b) % nn;
    end
    return r[31:0];
  endfunction

  // One run: start in the cycle after the previous done. poke_at > 0 pulses a
  // bogus start while busy; abort_at > 0 asserts reset at that cycle.
  task automatic run(input logic md, input logic [31:0] m, input logic [31:0] d,
                     input logic [31:0] n, input int poke_at, input int abort_at);
    exp_t e;
    exp_t got;
    int   lat;
    int   trigs;
    bit   seen;
    if (n < 32'd2) begin
      e = '{res: 32'd0, err: 1'b1, lat: 2, trigs: 0};
    end else begin
      e.res   = ref_modexp(m, d, n);
      e.err   = 1'b0;
      e.lat   = md ? (1 + 32 * 65) : (1 + 32 * (33 + $countones(d)));
      e.trigs = 32;
    end
    @(posedge clk); #1;
    mode  = md;
    m_in  = m;
    d_in  = d;
    n_in  = n;
    start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check_val("busy_after_accept", busy, 1);
    lat   = 0;
    trigs = 0;
    seen  = 0;
    while (lat < 5000) begin
      if (poke_at > 0 && lat == poke_at) begin
        start = 1'b1;
        mode  = ~md;
        m_in  = ~m;
        d_in  = ~d;
        n_in  = n ^ 32'h5;
      end else if (poke_at > 0 && lat == poke_at + 1) begin
        start = 1'b0;
      end
      if (trig) trigs++;
      if (done) begin
        seen = 1;
        break;
      end
      if (abort_at > 0 && lat == abort_at) begin
        reset = 1'b0;
        #1;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_trig", trig, 0);
        check_val("abort_err", err, 0);
        check_val("abort_result", result, 0);
        repeat (3) begin
          @(posedge clk); #1;
          check_val("abort_no_done", done, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_val("abort_idle", busy, 0);
        void'(sb.pop_front());
        return;
      end
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    if (!seen) begin
      check_val("timeout", 64'(lat), 64'(got.lat));
      return;
    end
    check_val("result", result, got.res);
    check_val("err", err, got.err);
    check_val("latency", 64'(lat), 64'(got.lat));
    check_val("trig_count", 64'(trigs), 64'(got.trigs));
    check_val("busy_at_done", busy, 0);
  endtask

  initial begin
    logic [31:0] rm, rd, rn;
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    start   = 1'b0;
    mode    = 1'b0;
    m_in    = '0;
    d_in    = '0;
    n_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    check_val("rst_trig", trig, 0);
    check_val("rst_result", result, 0);
    @(negedge clk);
    reset = 1'b1;

    run(1'b0, 32'd6, 32'd3, 32'd9, 0, 0);
    run(1'b0, 32'd8, 32'd7, 32'd13, 0, 0);
    run(1'b1, 32'd8, 32'd7, 32'd13, 0, 0);
    run(1'b1, 32'd8, 32'd1, 32'd13, 0, 0);
    run(1'b1, 32'd8, 32'hFFFF_FFFF, 32'd13, 0, 0);
    run(1'b1, 32'd8, 32'd0, 32'd13, 0, 0);
    run(1'b0, 32'd8, 32'd0, 32'd13, 0, 0);
    run(1'b0, 32'd0, 32'd5, 32'd13, 0, 0);
    run(1'b0, 32'd63, 32'd3, 32'd17, 0, 0);
    run(1'b1, 32'd63, 32'd3, 32'd17, 0, 0);
    run(1'b0, 32'd89, 32'd5, 32'd19, 0, 0);
    run(1'b1, 32'd89, 32'd5, 32'd19, 0, 0);
    run(1'b0, 32'd5, 32'd3, 32'd0, 0, 0);
    run(1'b1, 32'd5, 32'd3, 32'd1, 0, 0);
    run(1'b0, 32'd8, 32'd7, 32'd13, 0, 0);
    run(1'b1, 32'd8, 32'd7, 32'd13, 0, 200);
    run(1'b0, 32'd63, 32'd3, 32'd17, 100, 0);
    run(1'b1, 32'd89, 32'd5, 32'd19, 300, 0);

    for (int k = 0; k < 16; k++) begin
      rm = $urandom;
      rd = $urandom;
      do rn = $urandom; while (rn < 32'd2);
      run(k[0], rm, rd, rn, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
